bt_key_mode_sequencer: RTL and testbench



---
 rtl/bt_seq_pkg.sv | 30 +++
 rtl/bt_seq_timer.sv | 41 ++++
 rtl/bt_key_mode_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_bt_key_mode_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bt_seq_pkg.sv
// rtl/bt_seq_pkg.sv - shared types and constants for the Bluetooth KEY/reset sequencer
package bt_seq_pkg;

    // Sequencer phases, in the order a sequence walks through them.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        RST_HOLD  = 3'd2,
        BOOT_WAIT = 3'd3,
        DONE      = 3'd4
    } bt_seq_state_e;

    // Register map (word addresses)
    localparam logic [1:0] ADDR_CONTROL     = 2'd0;
    localparam logic [1:0] ADDR_STATUS      = 2'd1;
    localparam logic [1:0] ADDR_RST_CYCLES  = 2'd2;
    localparam logic [1:0] ADDR_BOOT_CYCLES = 2'd3;

    // CONTROL bit positions
    localparam int CTRL_MODE_BIT    = 0;
    localparam int CTRL_START_BIT   = 1;
    localparam int CTRL_IRQ_ENA_BIT = 2;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_ACTIVE_BIT = 1;
    localparam int STAT_DONE_BIT   = 2;
    localparam int STAT_READY_BIT  = 3;

endpackage

// File: rtl/bt_seq_timer.sv
// rtl/bt_seq_timer.sv - loadable down-counter with a one-cycle expiry pulse
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   load      load load_val and start counting (a zero load value counts as 1)
//   load_val  phase length in cycles
//   expired   high during the last cycle of the loaded interval
module bt_seq_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;
    logic             run;

    // A load of N makes expired rise in the N-th cycle after the load edge,
    // so a phase entered on that edge lasts exactly N cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= (load_val == '0) ? CNT_W'(1) : load_val;
            run <= 1'b1;
        end else if (run) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                run <= 1'b0;
            end
        end
    end

    assign expired = run && (cnt == CNT_W'(1));

endmodule

// File: rtl/bt_key_mode_sequencer.sv
// rtl/bt_key_mode_sequencer.sv - Avalon-MM sequencer for the SPP module KEY pin and reset
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata    Avalon-MM slave write side
//   readdata              combinational read data selected by address
//   bt_key                KEY pin (1 = AT mode, 0 = data mode)
//   bt_rst_n              module reset, active low
//   irq                   completion interrupt, present only with BT_KEY_SEQ_IRQ_EN
//
// Build option: define BT_KEY_SEQ_IRQ_EN to add the irq port and the IRQ_ENA bit.
module bt_key_mode_sequencer
    import bt_seq_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int SETUP_CYCLES = 1000,
    parameter int RST_DEFAULT  = 500000,
    parameter int BOOT_DEFAULT = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        bt_key,
    output logic        bt_rst_n
`ifdef BT_KEY_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    bt_seq_state_e    state, next_state;
    logic             mode;
    logic             active_mode;
    logic             done;
    logic             irq_ena;
    logic [CNT_W-1:0] rst_cycles;
    logic [CNT_W-1:0] boot_cycles;
    logic             bt_rst_n_q;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;

    logic wr;
    logic ctrl_wr;
    logic start_wr;
    logic done_clr;
    logic done_set;
    logic busy;
    logic ready;

    assign wr       = chipselect & ~write_n;
    assign ctrl_wr  = wr && (address == ADDR_CONTROL);
    assign start_wr = ctrl_wr && writedata[CTRL_START_BIT];
    assign done_clr = wr && (address == ADDR_STATUS) && writedata[STAT_DONE_BIT];
    assign done_set = (state == BOOT_WAIT) && tmr_expired;
    assign busy     = (state != IDLE);
    assign ready    = (state == IDLE) || (state == DONE);

    // One timer serves every phase; it is reloaded on each phase-entry edge,
    // which is also when the timing registers are sampled.
    bt_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            IDLE: begin
                if (start_wr) begin
                    next_state = SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(SETUP_CYCLES);
                end
            end
            SETUP: begin
                if (tmr_expired) begin
                    next_state = RST_HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = rst_cycles;
                end
            end
            RST_HOLD: begin
                if (tmr_expired) begin
                    next_state = BOOT_WAIT;
                    tmr_load   = 1'b1;
                    tmr_val    = boot_cycles;
                end
            end
            BOOT_WAIT: begin
                if (tmr_expired) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode        <= 1'b0;
            active_mode <= 1'b0;
            done        <= 1'b0;
            rst_cycles  <= CNT_W'(RST_DEFAULT);
            boot_cycles <= CNT_W'(BOOT_DEFAULT);
            bt_rst_n_q  <= 1'b1;
        end else begin
            // MODE follows every CONTROL write, even when START is ignored.
            if (ctrl_wr) begin
                mode <= writedata[CTRL_MODE_BIT];
            end
            if ((state == IDLE) && start_wr) begin
                active_mode <= writedata[CTRL_MODE_BIT];
            end
            // Set has priority over a simultaneous write-one-to-clear.
            if (done_set) begin
                done <= 1'b1;
            end else if (done_clr) begin
                done <= 1'b0;
            end
            if (wr && (address == ADDR_RST_CYCLES)) begin
                rst_cycles <= writedata[CNT_W-1:0];
            end
            if (wr && (address == ADDR_BOOT_CYCLES)) begin
                boot_cycles <= writedata[CNT_W-1:0];
            end
            // Registered from next_state so the pin is glitch-free yet aligned with RST_HOLD.
            bt_rst_n_q <= (next_state != RST_HOLD);
        end
    end

`ifdef BT_KEY_SEQ_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_ena <= 1'b0;
        end else if (ctrl_wr) begin
            irq_ena <= writedata[CTRL_IRQ_ENA_BIT];
        end
    end

    assign irq = done & irq_ena;
`else
    assign irq_ena = 1'b0;
`endif

    assign bt_key   = active_mode;
    assign bt_rst_n = bt_rst_n_q;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CONTROL: begin
                readdata[CTRL_MODE_BIT]    = mode;
                readdata[CTRL_IRQ_ENA_BIT] = irq_ena;
            end
            ADDR_STATUS: begin
                readdata[STAT_BUSY_BIT]   = busy;
                readdata[STAT_ACTIVE_BIT] = active_mode;
                readdata[STAT_DONE_BIT]   = done;
                readdata[STAT_READY_BIT]  = ready;
            end
            ADDR_RST_CYCLES:  readdata = 32'(rst_cycles);
            ADDR_BOOT_CYCLES: readdata = 32'(boot_cycles);
            default:          readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_bt_key_mode_sequencer.sv
// tb/tb_bt_key_mode_sequencer.sv - directed self-checking bench for bt_key_mode_sequencer
module tb_bt_key_mode_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        bt_key;
    logic        bt_rst_n;
`ifdef BT_KEY_SEQ_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bt_key_mode_sequencer #(
        .CNT_W        (32),
        .SETUP_CYCLES (4),
        .RST_DEFAULT  (3),
        .BOOT_DEFAULT (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .bt_key     (bt_key),
        .bt_rst_n   (bt_rst_n)
`ifdef BT_KEY_SEQ_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #1;
    endtask

    task automatic rd_sel(input logic [1:0] a);
        address = a;
        #1;
    endtask

    // Poll STATUS.DONE at most 100 cycles.
    task automatic wait_done();
        int n;
        n = 0;
        rd_sel(2'd1);
        while (readdata[2] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        int s;

        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        chk("rst_bt_key", {31'b0, bt_key}, 32'h0);
        chk("rst_bt_rst_n", {31'b0, bt_rst_n}, 32'h1);
        rd_sel(2'd1);
        chk("rst_status", readdata, 32'h8);
        rd_sel(2'd0);
        chk("rst_control", readdata, 32'h0);
        rd_sel(2'd2);
        chk("rst_rst_cycles", readdata, 32'd3);
        rd_sel(2'd3);
        chk("rst_boot_cycles", readdata, 32'd5);
`ifdef BT_KEY_SEQ_IRQ_EN
        chk("rst_irq", {31'b0, irq}, 32'h0);
`endif

        // Sequence in AT mode: 4 setup, 3 reset-low, 5 boot cycles.
        bus_write(2'd0, 32'h3);
        rd_sel(2'd1);
        chk("seq1_bt_key", {31'b0, bt_key}, 32'h1);
        chk("seq1_status_busy", readdata, 32'h3);
        n = 0;
        cnt = 0;
        while (bt_rst_n === 1'b1 && n < 50) begin cnt++; n++; step(); end
        chk("seq1_setup_len", cnt, 32'd4);
        cnt = 0;
        while (bt_rst_n === 1'b0 && n < 50) begin cnt++; n++; step(); end
        chk("seq1_rst_low_len", cnt, 32'd3);
        cnt = 0;
        while (readdata[2] !== 1'b1 && n < 50) begin cnt++; n++; step(); end
        chk("seq1_boot_len", cnt, 32'd5);
        step();
        chk("seq1_status_end", readdata, 32'hE);
        chk("seq1_bt_key_hold", {31'b0, bt_key}, 32'h1);

        // W1C then data-mode sequence with an ignored START mid-sequence.
        bus_write(2'd1, 32'h4);
        rd_sel(2'd1);
        chk("w1c_status", readdata, 32'hA);
        bus_write(2'd0, 32'h2);
        s = cyc;
        step();
        step();
        bus_write(2'd0, 32'h3);
        wait_done();
        chk("busy_start_len", cyc - s, 32'd12);
        step();
        chk("busy_start_status", readdata, 32'hC);
        chk("busy_start_bt_key", {31'b0, bt_key}, 32'h0);
        rd_sel(2'd0);
        chk("busy_start_mode_rd", readdata, 32'h1);

        // Zero RST_CYCLES treated as one cycle.
        bus_write(2'd1, 32'h4);
        bus_write(2'd2, 32'h0);
        rd_sel(2'd2);
        chk("rst0_readback", readdata, 32'h0);
        bus_write(2'd0, 32'h3);
        s = cyc;
        rd_sel(2'd1);
        n = 0;
        while (bt_rst_n === 1'b1 && n < 50) begin n++; step(); end
        cnt = 0;
        while (bt_rst_n === 1'b0 && n < 50) begin cnt++; n++; step(); end
        chk("rst0_low_len", cnt, 32'd1);
        wait_done();
        chk("rst0_total_len", cyc - s, 32'd10);

`ifdef BT_KEY_SEQ_IRQ_EN
        // Interrupt follows DONE while enabled, drops after W1C.
        bus_write(2'd1, 32'h4);
        bus_write(2'd2, 32'd3);
        chk("irq_before", {31'b0, irq}, 32'h0);
        bus_write(2'd0, 32'h7);
        chk("irq_busy", {31'b0, irq}, 32'h0);
        wait_done();
        chk("irq_with_done", {31'b0, irq}, 32'h1);
        step();
        bus_write(2'd1, 32'h4);
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        bus_write(2'd0, 32'h0);
`endif

        // Reset asserted during RST_HOLD.
        bus_write(2'd1, 32'h4);
        bus_write(2'd2, 32'd7);
        bus_write(2'd0, 32'h3);
        n = 0;
        while (bt_rst_n === 1'b1 && n < 50) begin n++; step(); end
        chk("mid_reached_rst_hold", {31'b0, bt_rst_n}, 32'h0);
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_bt_rst_n", {31'b0, bt_rst_n}, 32'h1);
        chk("mid_rst_bt_key", {31'b0, bt_key}, 32'h0);
        rd_sel(2'd1);
        chk("mid_rst_status", readdata, 32'h8);
        rd_sel(2'd2);
        chk("mid_rst_rst_cycles", readdata, 32'd3);
        rd_sel(2'd0);
        chk("mid_rst_control", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        rd_sel(2'd1);
        chk("post_rst_status", readdata, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
